// File: rtl/iz_param_loader.sv
// iz_param_loader: bit-serial (a,b,c,d) frame loader with atomic commit to the neuron core.
// Define IZ_PARAM_CHECKSUM_EN to require a trailing 8-bit byte-sum per frame.
module iz_param_loader #(
  parameter int PARAM_W = 8,
  parameter int NUM_PARAMS = 4,
  parameter logic [NUM_PARAMS*PARAM_W-1:0] DEFAULT_PARAMS = 32'h0214BF08
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_mode,
  input  logic                          serial_data,
  output logic [NUM_PARAMS*PARAM_W-1:0] params,
  output logic                          params_update,
  output logic                          params_ready,
  output logic                          load_busy,
  output logic                          frame_err
);
  localparam int DATA_W = NUM_PARAMS*PARAM_W;
`ifdef IZ_PARAM_CHECKSUM_EN
  localparam int CK_W = 8;
`else
  localparam int CK_W = 0;
`endif
  localparam int TOTAL = DATA_W + CK_W;
  localparam int CW = $clog2(TOTAL+1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [TOTAL-1:0] shadow;
  logic [CW-1:0] bit_cnt;
  logic pend;
  logic ck_ok;
  logic [DATA_W-1:0] data;
  assign data = shadow[TOTAL-1 -: DATA_W];
`ifdef IZ_PARAM_CHECKSUM_EN
  logic [7:0] ck_sum;
  always_comb begin
    ck_sum = '0;
    for (int i = 0; i < NUM_PARAMS; i++) ck_sum = ck_sum + 8'(data[i*PARAM_W +: PARAM_W]);
    ck_ok = ck_sum == shadow[7:0];
  end
`else
  assign ck_ok = 1'b1;
`endif
  // pend marks the first DONE cycle, where the full shadow is committed in one step
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shadow <= '0;
      bit_cnt <= '0;
      pend <= 1'b0;
      params <= DEFAULT_PARAMS;
      params_update <= 1'b0;
      params_ready <= 1'b0;
      load_busy <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      params_update <= 1'b0;
      case (state)
        IDLE: if (load_mode) begin
          shadow <= {{(TOTAL-1){1'b0}}, serial_data};
          bit_cnt <= CW'(1);
          frame_err <= 1'b0;
          load_busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: if (load_mode) begin
          shadow <= {shadow[TOTAL-2:0], serial_data};
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == CW'(TOTAL-1)) begin
            state <= DONE;
            load_busy <= 1'b0;
            pend <= 1'b1;
          end
        end else begin
          shadow <= '0;
          bit_cnt <= '0;
          frame_err <= 1'b1;
          load_busy <= 1'b0;
          state <= IDLE;
        end
        DONE: begin
          if (pend) begin
            pend <= 1'b0;
            if (ck_ok) begin
              params <= data;
              params_update <= 1'b1;
              params_ready <= 1'b1;
            end else frame_err <= 1'b1;
          end
          if (!load_mode) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
